// File: rtl/dsc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dsc_pkg
//  Description : Shared definitions for the stochastic-to-binary decoder.
//                Holds the default SNG geometry, the decoder state encoding
//                and a helper that derives the counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package dsc_pkg;

  // Default SNG geometry: bits per SNG and number of cascaded SNG inputs.
  localparam int SNG_WIDTH_DEF  = 10;
  localparam int NUM_INPUTS_DEF = 4;

  // Decoder state encoding. The constants are the encoding used in RTL;
  // the enum mirrors them so that debug tools can display state names.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ACCUM = ST_ACCUM,
    HOLD  = ST_HOLD
  } dsc_state_e;

  // One extra bit so a full-frame count of 2^(SNG_WIDTH*NUM_INPUTS) fits.
  function automatic int cnt_width(input int sng_width, input int num_inputs);
    return sng_width * num_inputs + 1;
  endfunction

endpackage : dsc_pkg
`default_nettype wire

// File: rtl/dsc_s2b_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : dsc_s2b_decoder_if
//  Description : Stream-in / result-out bundle of the stochastic-to-binary
//                decoder.
//                  start    - request a new decode frame
//                  sn_in    - stochastic bit, qualified by sn_valid
//                  sn_last  - marks the final bit of a frame
//                  sn_ready - decoder is accepting bits
//                  z_out    - ones-count of the frame
//                  z_len    - number of bits accepted in the frame
//                  z_valid  - result available, held until z_ready
//                  busy     - decoder is not idle
//                master = stimulus/consumer side, slave = decoder side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dsc_s2b_decoder_if #(
  parameter int CNT_W = dsc_pkg::SNG_WIDTH_DEF * dsc_pkg::NUM_INPUTS_DEF + 1
) ();

  logic             start;
  logic             sn_in;
  logic             sn_valid;
  logic             sn_last;
  logic             sn_ready;
  logic [CNT_W-1:0] z_out;
  logic [CNT_W-1:0] z_len;
  logic             z_valid;
  logic             z_ready;
  logic             busy;

  modport master (
    output start, sn_in, sn_valid, sn_last, z_ready,
    input  sn_ready, z_out, z_len, z_valid, busy
  );

  modport slave (
    input  start, sn_in, sn_valid, sn_last, z_ready,
    output sn_ready, z_out, z_len, z_valid, busy
  );

endinterface : dsc_s2b_decoder_if
`default_nettype wire

// File: rtl/dsc_s2b_acc.sv
`default_nettype none
// ============================================================================
//  Module      : dsc_s2b_acc
//  Description : CNT_W-bit up-counter with synchronous clear and count
//                enable. Clear has priority over enable.
//                  clk - system clock
//                  rst - asynchronous active-low reset
//                  clr - synchronous clear
//                  en  - increment by one
//                  q   - current count
//  Revision    : 1.0 - initial release
// ============================================================================
module dsc_s2b_acc #(
  parameter int CNT_W = 41
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + C_ONE;
    end
  end

endmodule : dsc_s2b_acc
`default_nettype wire

// File: rtl/dsc_s2b_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : dsc_s2b_decoder
//  Description : Stochastic-to-binary decoder. After start, counts the ones
//                and the number of accepted bits of a stochastic stream until
//                the frame is full (FRAME_LEN bits) or a bit with sn_last is
//                accepted, then presents the pair on z_out/z_len with a
//                valid/ready handshake. A finished frame whose result cannot
//                be handed to a still-occupied output register waits in HOLD.
//                  clk - system clock
//                  rst - asynchronous active-low reset
//                  bus - dsc_s2b_decoder_if slave (stream in, result out)
//  Revision    : 1.0 - initial release
// ============================================================================
module dsc_s2b_decoder
  import dsc_pkg::*;
#(
  parameter int SNG_WIDTH  = SNG_WIDTH_DEF,
  parameter int NUM_INPUTS = NUM_INPUTS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  dsc_s2b_decoder_if.slave   bus
);

  localparam int               CNT_W     = cnt_width(SNG_WIDTH, NUM_INPUTS);
  // 2^(SNG_WIDTH*NUM_INPUTS) is exactly the MSB of the counter width.
  localparam logic [CNT_W-1:0] FRAME_LEN = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] C_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_len;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_len_next;
  logic [CNT_W-1:0] r_z_out;
  logic [CNT_W-1:0] r_z_len;
  logic             r_z_valid;

  logic w_accept;
  logic w_frame_end;
  logic w_out_free;
  logic w_clr;
  logic w_load_accum;
  logic w_load_hold;

  assign w_accept     = (r_state == ST_ACCUM) && bus.sn_valid;
  // Values including the bit being accepted this cycle, so the terminating
  // bit is part of the result without an extra cycle.
  assign w_cnt_next   = w_cnt + {{(CNT_W-1){1'b0}}, bus.sn_in};
  assign w_len_next   = w_len + C_ONE;
  assign w_frame_end  = w_accept && (bus.sn_last || (w_len_next == FRAME_LEN));
  // Output register can take a new result if empty or being drained now.
  assign w_out_free   = !r_z_valid || bus.z_ready;
  assign w_clr        = (r_state == ST_IDLE) && bus.start;
  assign w_load_accum = w_frame_end && w_out_free;
  // In HOLD z_valid is necessarily set, so z_ready alone means hand-off.
  assign w_load_hold  = (r_state == ST_HOLD) && bus.z_ready;

  dsc_s2b_acc #(.CNT_W(CNT_W)) u_ones_acc (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .en  (w_accept && bus.sn_in),
    .q   (w_cnt)
  );

  dsc_s2b_acc #(.CNT_W(CNT_W)) u_len_acc (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .en  (w_accept),
    .q   (w_len)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_z_out   <= '0;
      r_z_len   <= '0;
      r_z_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE:  if (bus.start)   r_state <= ST_ACCUM;
        ST_ACCUM: if (w_frame_end) r_state <= w_out_free ? ST_IDLE : ST_HOLD;
        ST_HOLD:  if (bus.z_ready) r_state <= ST_IDLE;
        default:                   r_state <= ST_IDLE;
      endcase

      if (w_load_accum) begin
        r_z_out   <= w_cnt_next;
        r_z_len   <= w_len_next;
        r_z_valid <= 1'b1;
      end else if (w_load_hold) begin
        // Counters were frozen on entry to HOLD and carry the final values.
        r_z_out   <= w_cnt;
        r_z_len   <= w_len;
        r_z_valid <= 1'b1;
      end else if (r_z_valid && bus.z_ready) begin
        r_z_valid <= 1'b0;
      end
    end
  end

  assign bus.sn_ready = (r_state == ST_ACCUM);
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.z_out    = r_z_out;
  assign bus.z_len    = r_z_len;
  assign bus.z_valid  = r_z_valid;

endmodule : dsc_s2b_decoder
`default_nettype wire

// File: doc/dsc_s2b_decoder.md
DSC_S2B_DECODER -- requirements
Module: dsc_s2b_decoder

Interface
REQ-001 SHALL have parameter SNG_WIDTH, default 10: per-input SNG resolution in bits.
REQ-002 SHALL have parameter NUM_INPUTS, default 4: number of cascaded SNG inputs feeding the stream.
REQ-003 SHALL use the following derived constants:
- FRAME_LEN = 2^(SNG_WIDTH*NUM_INPUTS).
- CNT_W = SNG_WIDTH*NUM_INPUTS+1, sized so a count of FRAME_LEN fits.
REQ-004 SHALL use one clock; reset is asynchronous and active-low. Ports clk and rst; rst low = reset.
REQ-005 SHALL have these ports:
- clk  in  1  system clock.
- rst  in  1  async active-low reset.
- start  in  1  request a new decode frame.
- sn_in  in  1  stochastic bit.
- sn_valid  in  1  sn_in qualifier.
- sn_last  in  1  early-terminate; marks the final bit, sampled with sn_valid.
- sn_ready  out  1  decoder accepts bits.
- z_out  out  CNT_W  ones-count of the frame.
- z_len  out  CNT_W  bits accepted in the frame.
- z_valid  out  1  result available.
- z_ready  in  1  consumer accepts result.
- busy  out  1  state is not IDLE.

Function
REQ-006 SHALL implement three states: IDLE, ACCUM, HOLD.
REQ-007 SHALL, in IDLE, drive sn_ready=0; start=1 moves to ACCUM with cnt=0 and len=0.
REQ-008 SHALL, in ACCUM, drive sn_ready=1.
- A bit is accepted on any cycle with sn_valid=1.
- On acceptance: cnt += sn_in, len += 1.
- Cycles with sn_valid=0 leave cnt and len unchanged.
REQ-009 SHALL end the frame on the accepted bit that makes len==FRAME_LEN, or on any accepted bit with sn_last=1, whichever comes first.
REQ-010 SHALL include the terminating bit in both the count and the length.
REQ-011 SHALL, at frame end with the output register free (z_valid=0, or z_valid=1 and z_ready=1 in the same cycle), do all of the following next cycle:
- load z_out=cnt_final and z_len=len_final;
- assert z_valid;
- return to IDLE.
Latency is 1 cycle after the last accepted bit.
REQ-012 SHALL, at frame end with the output register occupied and z_ready=0, enter HOLD.
- Drive sn_ready=0 and hold the final count.
- On the cycle z_ready=1, load the new result and keep z_valid=1.
- Then return to IDLE.
REQ-013 SHALL hold z_out and z_len stable while z_valid=1 and z_ready=0.
REQ-014 SHALL deassert z_valid the cycle after z_valid&z_ready, unless a new result loads in that same cycle.
REQ-015 SHALL ignore start in ACCUM and HOLD.
REQ-016 SHALL honour start in IDLE in the same cycle that a result is being handed off.
REQ-017 SHALL never wrap cnt or len: CNT_W covers FRAME_LEN exactly.
REQ-018 SHALL drive busy=1 in ACCUM and HOLD.

Reset
REQ-019 SHALL, on rst low, asynchronously force all of the following:
- state=IDLE;
- cnt=0, len=0;
- z_out=0, z_len=0;
- z_valid=0, sn_ready=0, busy=0.
REQ-020 SHALL discard any partial frame on reset mid-operation.
REQ-021 SHALL, after reset deasserts, require start before accepting bits.

Structure
REQ-022 SHALL place SNG_WIDTH/NUM_INPUTS defaults and the state enum (IDLE, ACCUM, HOLD) in shared package dsc_pkg.
REQ-023 SHALL instantiate one sub-module, dsc_s2b_acc: a CNT_W-bit counter with sync clear and enable, used twice (ones count, length).
REQ-024 SHALL run entirely on clk; no derived or ripple clocks.

Verification (SNG_WIDTH=3, NUM_INPUTS=2 -> FRAME_LEN=64, CNT_W=7)
REQ-025 SHALL cover: start, then 64 consecutive sn_in=1 bits -> z_out=64, z_len=64, z_valid high 1 cycle after bit 64.
REQ-026 SHALL cover: alternating 1,0 pattern with sn_valid low every third cycle, 64 bits accepted -> z_out=32, z_len=64.
REQ-027 SHALL cover: sn_last on the 10th accepted bit, 7 ones in those 10 bits -> z_out=7, z_len=10, then IDLE with busy=0.
REQ-028 SHALL cover: z_ready low, two back-to-back frames with counts 5 and 9 ->
- second frame enters HOLD with sn_ready=0;
- raising z_ready yields z_out=5 first, then 9;
- no loss or duplication.
REQ-029 SHALL cover: rst low after 20 accepted bits -> all outputs 0 immediately; new frame of 64 zeros -> z_out=0, z_len=64.
REQ-030 SHALL cover: start pulsed during ACCUM -> no effect; the frame completes with the correct count.
